pulse_receiver_capture: RTL and testbench
=========================================

# pulse_receiver_capture

Capture-side counterpart of the pulse transmitter. It samples an asynchronous input, timestamps every level change and pushes {level, duration} records into a small FIFO for the TinyQV peripheral register interface to read. It supports IR/remote-style pulse decoding and loopback checking of the transmitter.

## Interface
Parameters:
- DUR_W, 15: duration field width in ticks.
- FIFO_DEPTH, 4: record FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  capture enable
- prescale  in  8  tick period = prescale+1 clk cycles
- idle_thresh  in  DUR_W  idle timeout in ticks; 0 disables timeout
- sig_in  in  1  asynchronous pulse input
- rd_en  in  1  pop head record
- rd_data  out  DUR_W+1  head record: [DUR_W] = segment level, [DUR_W-1:0] = duration
- rd_valid  out  1  FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  records held
- overflow  out  1  sticky: record dropped because FIFO was full
- clr_overflow  in  1  clears overflow
- idle  out  1  receiver in IDLE state

## Operation
- Synchronizer: two flops on sig_in, reset 0, giving sig_s. sig_prev is sig_s delayed one cycle, reset 0. Edge = sig_s != sig_prev. Both polarities count.
- Prescaler: pcnt counts 0..prescale. A tick occurs when pcnt == prescale, then pcnt wraps to 0. pcnt clears on every edge and while en=0. With prescale=0 there is a tick every cycle.
- FSM states:
  - IDLE (reset state): on an edge with en=1 → MEASURE, dur=0.
  - MEASURE: dur increments on each tick and saturates at all-ones.
    - On an edge: push {sig_prev, dur'}, where dur' includes a tick occurring in the same cycle. Then dur=0 and the FSM stays in MEASURE.
    - Otherwise, if idle_thresh≠0 and dur' == idle_thresh: push {sig_s, idle_thresh} → IDLE.
- Duration requirement: the recorded duration equals floor(N/(prescale+1)), saturated, where N is the number of clk cycles between the two edge-detect cycles.
- en=0 forces IDLE, clears dur and pcnt, and generates no pushes. FIFO contents, overflow and reads are unaffected.
- FIFO:
  - rd_data shows the head record whenever rd_valid=1.
  - rd_en while empty is ignored.
  - Push while full drops the record and sets overflow.
  - Push and pop in the same cycle while full: both succeed and count is unchanged.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
- overflow: clr_overflow clears it, but a set in the same cycle wins.

## Timing
- Reset values: rd_valid=0, rd_data=0, fifo_count=0, overflow=0, idle=1.
- sig_in → edge detect: 2 cycles of synchronizer latency, plus 1 cycle when the glitch filter is compiled in.
- Edge-detect cycle → rd_valid/fifo_count update: +1 cycle. Records are registered.
- rd_en pop: the next record appears on rd_data the following cycle.
- Reset asserted mid-measurement discards the partial segment and empties the FIFO.

## Configuration
- PULSE_RECEIVER_GLITCH_FILTER_EN defined:
  - Adds a third sample stage; sig_s becomes the majority of the three stages.
  - Single-cycle input glitches are suppressed.
  - Latency is +1 cycle.
- Not defined: sig_s is the second synchronizer flop directly.

## Structure
- Shared package pulse_transmitter_pkg holds:
  - FSM state enum (IDLE, MEASURE).
  - Record field index constants: level bit = DUR_W.
  - Default DUR_W/FIFO_DEPTH constants.
- One sub-module, pulse_receiver_fifo: synchronous FIFO with push/pop/full/empty/count, storing DUR_W+1-bit records.

## Test plan
- prescale=0, idle_thresh=0: sig_in low→high, held 10 cycles, then low 5 cycles, then high → records {1,10} then {0,5}. rd_valid rises 1 cycle after each edge detect.
- prescale=3: high segment of 40 cycles → {1,10}. High segment of 42 cycles → {1,10}; the remainder is truncated.
- idle_thresh=20, prescale=0: one rising edge then constant high → single record {1,20}, then idle=1. The next edge restarts MEASURE with no record for the gap.
- FIFO_DEPTH=4: 6 segments without reads → fifo_count=4, overflow=1, and the first 4 records are retained in order. clr_overflow → 0. Simultaneous rd_en and push at full → count stays 4 and the order is preserved.
- Saturation: DUR_W=4, prescale=0, 30-cycle segment → {level,15}.
- With PULSE_RECEIVER_GLITCH_FILTER_EN: 1-cycle high glitch → no record. A 2-cycle pulse → recorded, with edge latency 3 cycles.

Source files
------------

// File: rtl/pulse_transmitter_pkg.sv
// Shared types and constants for the pulse transmitter/receiver pair.
// Records are {level, duration}; the level bit sits at index DUR_W.
package pulse_transmitter_pkg;

  localparam int DUR_W_DEF      = 15;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } rx_state_e;

  function automatic int rec_lvl_bit(input int dur_w);
    return dur_w;
  endfunction

endpackage

// File: rtl/pulse_receiver_fifo.sv
// Small synchronous record FIFO. Push while full drops (reported on drop)
// unless a pop happens in the same cycle; pop while empty is ignored.
module pulse_receiver_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;
    drop    = push && full && !pop;
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
    mem_d = mem_q;
    if (push_ok) mem_d[wptr_q] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pulse_receiver_capture.sv
// Timestamps level changes on an async input and queues {level, duration}.
// Define PULSE_RECEIVER_GLITCH_FILTER_EN for a majority-vote glitch filter.
module pulse_receiver_capture
  import pulse_transmitter_pkg::*;
#(
  parameter int DUR_W      = DUR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [7:0]                    prescale,
  input  logic [DUR_W-1:0]              idle_thresh,
  input  logic                          sig_in,
  input  logic                          rd_en,
  output logic [DUR_W:0]                rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          idle
);

  localparam int LVL_BIT = rec_lvl_bit(DUR_W);

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  localparam int SYNC_STAGES = 4;
`else
  localparam int SYNC_STAGES = 2;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sig_s;
  logic                   sig_prev_q, sig_prev_d;
  logic [7:0]             pcnt_q, pcnt_d;
  logic [DUR_W-1:0]       dur_q, dur_d, dur_inc;
  rx_state_e              state_q, state_d;
  logic                   overflow_q, overflow_d;
  logic                   edge_det, tick;
  logic                   push;
  logic [DUR_W:0]         rec;
  logic                   fifo_full, fifo_empty, fifo_drop;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  // Vote over three stages behind the metastability flop: one-cycle blips lose.
  assign sig_s = (sync_q[1] & sync_q[2]) | (sync_q[1] & sync_q[3]) |
                 (sync_q[2] & sync_q[3]);
`else
  assign sig_s = sync_q[1];
`endif

  always_comb begin
    sig_prev_d = sig_s;
    edge_det   = sig_s ^ sig_prev_q;
    tick       = (pcnt_q == prescale);
    pcnt_d     = (!en || edge_det || tick) ? 8'd0 : pcnt_q + 8'd1;
    // A tick in the edge cycle still belongs to the segment being closed.
    dur_inc    = (tick && !(&dur_q)) ? dur_q + DUR_W'(1) : dur_q;

    state_d = state_q;
    dur_d   = dur_q;
    push    = 1'b0;
    rec     = '0;
    if (!en) begin
      state_d = ST_IDLE;
      dur_d   = '0;
    end else if (state_q == ST_IDLE) begin
      if (edge_det) begin
        state_d = ST_MEASURE;
        dur_d   = '0;
      end
    end else begin
      if (edge_det) begin
        push                = 1'b1;
        rec[LVL_BIT]        = sig_prev_q;
        rec[DUR_W-1:0]      = dur_inc;
        dur_d               = '0;
      end else if (idle_thresh != '0 && dur_inc == idle_thresh) begin
        push                = 1'b1;
        rec[LVL_BIT]        = sig_s;
        rec[DUR_W-1:0]      = idle_thresh;
        dur_d               = '0;
        state_d             = ST_IDLE;
      end else begin
        dur_d = dur_inc;
      end
    end

    overflow_d = fifo_drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      sig_prev_q <= 1'b0;
      pcnt_q     <= '0;
      dur_q      <= '0;
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      sig_prev_q <= sig_prev_d;
      pcnt_q     <= pcnt_d;
      dur_q      <= dur_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  pulse_receiver_fifo #(
    .W     (DUR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (rec),
    .pop   (rd_en),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign rd_valid = !fifo_empty;
  assign overflow = overflow_q;
  assign idle     = (state_q == ST_IDLE);

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_pulse_receiver_capture.sv
// Self-checking bench for pulse_receiver_capture: directed scenarios plus
// randomized segment trains checked against an arithmetic record model.
module tb_pulse_receiver_capture;

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  localparam int LAT = 3, MINLEN = 2;
`else
  localparam int LAT = 2, MINLEN = 1;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [7:0]  prescale = 8'd0;
  logic [14:0] idle_thresh = '0;
  logic        sig_in = 1'b0, rd_en = 1'b0, clr_overflow = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, overflow, idle;
  logic [2:0]  fifo_count;

  logic [7:0]  prescale4 = 8'd0;
  logic [3:0]  idle_thresh4 = '0;
  logic        sig4 = 1'b0, rd_en4 = 1'b0, clr4 = 1'b0;
  logic [4:0]  rd_data4;
  logic        rd_valid4, ovf4, idle4;
  logic [2:0]  cnt4;

  int checks = 0, failures = 0;
  int cyc = 0, last_tog = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_receiver_capture dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale),
    .idle_thresh(idle_thresh), .sig_in(sig_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .overflow(overflow), .clr_overflow(clr_overflow), .idle(idle)
  );

  pulse_receiver_capture #(.DUR_W(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale4),
    .idle_thresh(idle_thresh4), .sig_in(sig4), .rd_en(rd_en4),
    .rd_data(rd_data4), .rd_valid(rd_valid4), .fifo_count(cnt4),
    .overflow(ovf4), .clr_overflow(clr4), .idle(idle4)
  );

  // Record for a segment of n cycles: ticks floor(n/(p+1)), saturated, capped by timeout.
  function automatic logic [15:0] exp_rec(input logic lvl, input int n, input int p, input int t);
    int q;
    logic [14:0] d;
    q = n / (p + 1);
    if (q > 32767) q = 32767;
    if (t != 0 && q >= t) q = t;
    d = 15'(q);
    return {lvl, d};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tog(output logic lvl, output int len);
    lvl = sig_in;
    len = cyc - last_tog;
    last_tog = cyc;
    sig_in = ~sig_in;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; en = 1'b1; sig_in = 1'b0; sig4 = 1'b0;
    rd_en = 1'b0; rd_en4 = 1'b0; clr_overflow = 1'b0; clr4 = 1'b0;
    prescale = 8'd0; idle_thresh = '0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);
    last_tog = cyc;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
  endtask

  task automatic test_basic();
    logic l; int n;
    reset_dut();
    tog(l, n);
    wait_cyc(LAT + 1);
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL basic_measuring idle=%b exp=0", idle); end
    wait_cyc(10 - (LAT + 1));
    tog(l, n);
    wait_cyc(LAT);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_early got=%b exp=0", rd_valid); end
    wait_cyc(1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h800a) begin failures++; $display("FAIL basic_rec0 valid=%b data=%h exp=1/800a", rd_valid, rd_data); end
    wait_cyc(5 - (LAT + 1));
    tog(l, n);
    wait_cyc(LAT + 1);
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", fifo_count); end
    pop1();
    checks++; if (rd_data !== 16'h0005 || fifo_count !== 3'd1) begin failures++; $display("FAIL basic_rec1 data=%h cnt=%0d exp=0005/1", rd_data, fifo_count); end
  endtask

  task automatic test_prescale();
    logic l; int n;
    reset_dut();
    prescale = 8'd3;
    tog(l, n); wait_cyc(40);
    tog(l, n); wait_cyc(42);
    tog(l, n); wait_cyc(LAT + 1);
    checks++; if (fifo_count !== 3'd2 || rd_data !== 16'h800a) begin failures++; $display("FAIL prescale_40 cnt=%0d data=%h exp=2/800a", fifo_count, rd_data); end
    pop1();
    checks++; if (rd_data !== 16'h000a) begin failures++; $display("FAIL prescale_42 data=%h exp=000a", rd_data); end
  endtask

  task automatic test_idle_timeout();
    logic l; int n;
    logic [15:0] e;
    reset_dut();
    idle_thresh = 15'd20;
    tog(l, n); wait_cyc(30);
    checks++; if (fifo_count !== 3'd1 || rd_data !== 16'h8014) begin failures++; $display("FAIL idle_rec cnt=%0d data=%h exp=1/8014", fifo_count, rd_data); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL idle_state got=%b exp=1", idle); end
    tog(l, n); wait_cyc(LAT + 1);
    checks++; if (idle !== 1'b0 || fifo_count !== 3'd1) begin failures++; $display("FAIL idle_restart idle=%b cnt=%0d exp=0/1", idle, fifo_count); end
    wait_cyc(4);
    tog(l, n);
    e = exp_rec(l, n, 0, 20);
    wait_cyc(LAT + 1);
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL idle_count got=%0d exp=2", fifo_count); end
    pop1();
    checks++; if (rd_data !== e) begin failures++; $display("FAIL idle_next_rec got=%h exp=%h", rd_data, e); end
  endtask

  task automatic test_enable();
    logic l; int n;
    logic [15:0] e;
    reset_dut();
    tog(l, n); wait_cyc(5);
    en = 1'b0; wait_cyc(2);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL en_idle got=%b exp=1", idle); end
    tog(l, n); wait_cyc(3); tog(l, n); wait_cyc(LAT + 3);
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL en_nopush cnt=%0d exp=0", fifo_count); end
    en = 1'b1; wait_cyc(3);
    tog(l, n); wait_cyc(6);
    tog(l, n); e = exp_rec(l, n, 0, 0);
    wait_cyc(LAT + 1);
    checks++; if (fifo_count !== 3'd1 || rd_data !== e) begin failures++; $display("FAIL en_resume cnt=%0d data=%h exp=1/%h", fifo_count, rd_data, e); end
  endtask

  task automatic test_overflow();
    logic l; int n;
    logic [15:0] rec[7];
    reset_dut();
    tog(l, n); wait_cyc(8);
    reset_dut();
    wait_cyc(LAT + 2);
    checks++; if (fifo_count !== 3'd0 || idle !== 1'b1) begin failures++; $display("FAIL midreset cnt=%0d idle=%b exp=0/1", fifo_count, idle); end
    tog(l, n);
    for (int i = 0; i < 6; i++) begin
      wait_cyc(3 + i);
      tog(l, n);
      rec[i] = exp_rec(l, n, 0, 0);
    end
    wait_cyc(LAT + 1);
    checks++; if (fifo_count !== 3'd4 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_full cnt=%0d ovf=%b exp=4/1", fifo_count, overflow); end
    checks++; if (rd_data !== rec[0]) begin failures++; $display("FAIL ovf_head got=%h exp=%h", rd_data, rec[0]); end
    clr_overflow = 1'b1; wait_cyc(1); clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    wait_cyc(4);
    tog(l, n); rec[6] = exp_rec(l, n, 0, 0);
    wait_cyc(LAT);
    rd_en = 1'b1; wait_cyc(1); rd_en = 1'b0;
    checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_pushpop cnt=%0d ovf=%b exp=4/0", fifo_count, overflow); end
    wait_cyc(3);
    tog(l, n);
    wait_cyc(LAT);
    clr_overflow = 1'b1; wait_cyc(1); clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b1 || fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_set_wins ovf=%b cnt=%0d exp=1/4", overflow, fifo_count); end
    for (int i = 1; i < 7; i++) begin
      if (i == 4 || i == 5) continue;
      checks++; if (rd_data !== rec[i]) begin failures++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, rd_data, rec[i]); end
      pop1();
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained valid=%b exp=0", rd_valid); end
  endtask

  task automatic test_saturation();
    reset_dut();
    sig4 = 1'b1; wait_cyc(30);
    sig4 = 1'b0; wait_cyc(7);
    sig4 = 1'b1; wait_cyc(LAT + 1);
    checks++; if (cnt4 !== 3'd2 || rd_data4 !== 5'b11111) begin failures++; $display("FAIL sat_rec cnt=%0d data=%b exp=2/11111", cnt4, rd_data4); end
    rd_en4 = 1'b1; wait_cyc(1); rd_en4 = 1'b0;
    checks++; if (rd_data4 !== 5'b00111) begin failures++; $display("FAIL sat_short data=%b exp=00111", rd_data4); end
  endtask

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic l; int n;
    reset_dut();
    tog(l, n); wait_cyc(10);
    sig_in = 1'b0; wait_cyc(1); sig_in = 1'b1;
    wait_cyc(10);
    tog(l, n);
    wait_cyc(LAT + 1);
    checks++; if (fifo_count !== 3'd1 || rd_data !== 16'h8015) begin failures++; $display("FAIL glitch_suppressed cnt=%0d data=%h exp=1/8015", fifo_count, rd_data); end
    tog(l, n); wait_cyc(2);
    tog(l, n); wait_cyc(1);
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL glitch_latency_early cnt=%0d exp=1", fifo_count); end
    wait_cyc(1);
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL glitch_latency cnt=%0d exp=2", fifo_count); end
    wait_cyc(LAT + 1);
    pop1(); pop1();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h8002) begin failures++; $display("FAIL glitch_pulse valid=%b data=%h exp=1/8002", rd_valid, rd_data); end
  endtask
`endif

  task automatic test_random();
    logic [15:0] expq[$];
    logic [15:0] got[$];
    int lens[8];
    int p, t;
    logic lvl;
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      p = $urandom_range(0, 3);
      t = (r % 2 == 1) ? $urandom_range(3, 12) : 0;
      prescale = 8'(p);
      idle_thresh = 15'(t);
      expq.delete(); got.delete();
      lvl = 1'b1;
      for (int i = 0; i < 8; i++) begin
        lens[i] = $urandom_range(MINLEN, 40);
        expq.push_back(exp_rec(lvl, lens[i], p, t));
        lvl = ~lvl;
      end
      if (t != 0) expq.push_back(exp_rec(lvl, 100000, p, t));
      rd_en = 1'b1;
      sig_in = ~sig_in;
      for (int i = 0; i < 8; i++) begin
        repeat (lens[i]) begin
          @(negedge clk);
          if (rd_valid) got.push_back(rd_data);
        end
        sig_in = ~sig_in;
      end
      repeat (13 * 4 + LAT + 10) begin
        @(negedge clk);
        if (rd_valid) got.push_back(rd_data);
      end
      rd_en = 1'b0;
      checks++;
      if (got.size() !== expq.size()) begin
        failures++; $display("FAIL rand_count round=%0d got=%0d exp=%0d", r, got.size(), expq.size());
      end else begin
        for (int i = 0; i < expq.size(); i++) begin
          checks++;
          if (got[i] !== expq[i]) begin failures++; $display("FAIL rand_rec round=%0d idx=%0d got=%h exp=%h", r, i, got[i], expq[i]); end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_idle_timeout();
    test_enable();
    test_overflow();
    test_saturation();
`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
